// File: rtl/edge_event_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_arbiter_if
//  Purpose  : Valid/ready event port carrying the granted channel index.
//  Revision : 1.0 - initial release
// ============================================================================
interface edge_event_arbiter_if #(
    parameter int N_CH = 4
);
    localparam int CH_W = $clog2(N_CH);

    logic            evt_valid;
    logic [CH_W-1:0] evt_ch;
    logic            evt_ready;

    modport master (output evt_valid, output evt_ch, input evt_ready);
    modport slave  (input evt_valid, input evt_ch, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : edge_event_arbiter
//  Purpose  : Rising-edge event latch with round-robin grant onto one port.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_event_arbiter #(
    parameter  int N_CH  = 4,
    parameter  int CNT_W = 8,
    localparam int CH_W  = $clog2(N_CH)
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic [N_CH-1:0]   data_in_i,
    input  wire logic [N_CH-1:0]   en_mask_i,
    input  wire logic              ovr_clr_i,
    edge_event_arbiter_if.master   evt_if,
    output      logic [N_CH-1:0]   pending_o,
    output      logic [N_CH-1:0]   overrun_o,
    output      logic [CNT_W-1:0]  ovr_cnt_o
);

    localparam logic [0:0] c_IDLE  = 1'b0;
    localparam logic [0:0] c_OFFER = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [N_CH-1:0]  prev_q;
    logic [N_CH-1:0]  pending_q, pending_d;
    logic [N_CH-1:0]  overrun_q, overrun_d;
    logic [CNT_W-1:0] ovr_cnt_q, ovr_cnt_d;
    logic             valid_q, valid_d;
    logic [CH_W-1:0]  ch_q, ch_d;
    logic [CH_W-1:0]  last_q, last_d;

    logic [N_CH-1:0]  rise, acc_vec, ovr_new;
    logic             accept;
    logic [CNT_W:0]   cnt_sum;
    logic [CH_W-1:0]  pick, idx;

    // Pending/overrun bookkeeping; an accept of a channel frees its slot
    // for a same-cycle rise so that case never counts as an overrun.
    always_comb begin
        rise    = data_in_i & ~prev_q & en_mask_i;
        accept  = valid_q & evt_if.evt_ready;
        acc_vec = '0;
        if (accept) acc_vec[ch_q] = 1'b1;
        ovr_new   = rise & pending_q & ~acc_vec;
        pending_d = (pending_q & ~acc_vec) | rise;
        overrun_d = (ovr_clr_i ? {N_CH{1'b0}} : overrun_q) | ovr_new;
        cnt_sum   = {1'b0, (ovr_clr_i ? {CNT_W{1'b0}} : ovr_cnt_q)};
        for (int i = 0; i < N_CH; i++) begin
            cnt_sum = cnt_sum + (CNT_W+1)'(ovr_new[i]);
        end
        ovr_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
    end

    // Scan downward so the nearest pending channel after last_q wins.
    always_comb begin
        pick = last_q;
        idx  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            idx = CH_W'((int'(last_q) + k) % N_CH);
            if (pending_q[idx]) pick = idx;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= c_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_IDLE:  if (|pending_q) state_d = c_OFFER;
            c_OFFER: if (accept)     state_d = c_IDLE;
            default: state_d = c_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        ch_d    = ch_q;
        last_d  = last_q;
        case (state_q)
            c_IDLE: begin
                if (|pending_q) begin
                    valid_d = 1'b1;
                    ch_d    = pick;
                end
            end
            c_OFFER: begin
                if (accept) begin
                    valid_d = 1'b0;
                    last_d  = ch_q;
                end
            end
            default: ;
        endcase
    end

    // prev_q tracks the inputs even in reset so a level held through reset
    // is not seen as an edge afterwards.
    always_ff @(posedge clk) begin
        prev_q <= data_in_i;
        if (reset) begin
            pending_q <= '0;
            overrun_q <= '0;
            ovr_cnt_q <= '0;
            valid_q   <= 1'b0;
            ch_q      <= '0;
            last_q    <= CH_W'(N_CH - 1);
        end else begin
            pending_q <= pending_d;
            overrun_q <= overrun_d;
            ovr_cnt_q <= ovr_cnt_d;
            valid_q   <= valid_d;
            ch_q      <= ch_d;
            last_q    <= last_d;
        end
    end

    assign evt_if.evt_valid = valid_q;
    assign evt_if.evt_ch    = ch_q;
    assign pending_o        = pending_q;
    assign overrun_o        = overrun_q;
    assign ovr_cnt_o        = ovr_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_edge_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_event_arbiter
//  Purpose  : Directed stimulus checked against a cycle model of the arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_event_arbiter;

    localparam int N     = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk;
    logic             reset;
    logic [N-1:0]     data_in;
    logic [N-1:0]     en_mask;
    logic             ovr_clr;
    logic [N-1:0]     pending;
    logic [N-1:0]     overrun;
    logic [CNT_W-1:0] ovr_cnt;

    int vectors;
    int errors;

    edge_event_arbiter_if #(.N_CH(N)) bus ();

    edge_event_arbiter #(.N_CH(N), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in_i (data_in),
        .en_mask_i (en_mask),
        .ovr_clr_i (ovr_clr),
        .evt_if    (bus),
        .pending_o (pending),
        .overrun_o (overrun),
        .ovr_cnt_o (ovr_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: event set per channel, a "currently offering" flag and
    // the last granted channel; the bubble after accept falls out naturally.
    bit           m_init;
    bit           m_valid;
    int           m_ch, m_last, m_cnt;
    bit [N-1:0]   m_pend, m_ovr, m_prev;

    always @(posedge clk) begin
        bit [N-1:0] old_pend;
        bit         acc, rise, taken, found;
        int         add, c;
        if (reset) begin
            m_valid = 0; m_ch = 0; m_last = N - 1; m_cnt = 0;
            m_pend = '0; m_ovr = '0;
        end else begin
            old_pend = m_pend;
            acc = m_valid && bus.evt_ready;
            add = 0;
            if (ovr_clr) begin m_ovr = '0; m_cnt = 0; end
            for (int i = 0; i < N; i++) begin
                rise  = data_in[i] && !m_prev[i] && en_mask[i];
                taken = acc && (m_ch == i);
                if (rise && old_pend[i] && !taken) begin m_ovr[i] = 1'b1; add++; end
                if (taken) m_pend[i] = 1'b0;
                if (rise)  m_pend[i] = 1'b1;
            end
            m_cnt = (m_cnt + add > CMAX) ? CMAX : m_cnt + add;
            if (m_valid) begin
                if (acc) begin m_valid = 0; m_last = m_ch; end
            end else begin
                found = 0;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (!found && old_pend[c]) begin found = 1; m_ch = c; m_valid = 1; end
                end
            end
        end
        m_prev = data_in;
        m_init = 1;
    end

    always @(negedge clk) begin
        if (m_init) begin
            check("valid",   32'(bus.evt_valid), 32'(m_valid));
            check("ch",      32'(bus.evt_ch),    32'(m_ch));
            check("pending", 32'(pending),       32'(m_pend));
            check("overrun", 32'(overrun),       32'(m_ovr));
            check("ovr_cnt", 32'(ovr_cnt),       32'(m_cnt));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    int got_ch[$];
    int got_cyc[$];

    // Records grants (valid & ready at the negedge) for up to n cycles.
    task automatic collect(input int n);
        got_ch.delete();
        got_cyc.delete();
        for (int c = 0; c < n; c++) begin
            tick();
            if (bus.evt_valid && bus.evt_ready) begin
                got_ch.push_back(int'(bus.evt_ch));
                got_cyc.push_back(c);
            end
        end
    endtask

    initial begin
        bit ok;
        vectors = 0; errors = 0; m_init = 0;
        reset = 1'b1; data_in = 4'b0001; en_mask = 4'b1111; ovr_clr = 1'b0;
        bus.evt_ready = 1'b0;

        // Input held high through reset gives no event
        tick(3);
        reset = 1'b0;
        tick(3);
        check("t1_pending", 32'(pending), 32'h0);
        check("t1_valid",   32'(bus.evt_valid), 32'h0);
        data_in = 4'b0000;
        tick();

        // Single edge on ch2, first-event latency
        data_in = 4'b0100; bus.evt_ready = 1'b1;
        tick();
        check("t2_pend_set", 32'(pending), 32'h4);
        check("t2_no_valid", 32'(bus.evt_valid), 32'h0);
        tick();
        check("t2_valid", 32'(bus.evt_valid), 32'h1);
        check("t2_ch",    32'(bus.evt_ch), 32'h2);
        tick();
        check("t2_pend_clr", 32'(pending), 32'h0);
        data_in = 4'b0000;
        tick(2);

        // Round robin from reset: 0,1,3 two cycles apart, then wrap to 0
        reset = 1'b1; tick(2); reset = 1'b0;
        data_in = 4'b1011;
        collect(10);
        check("t3_ngrants", 32'(got_ch.size()), 32'd3);
        if (got_ch.size() == 3) begin
            check("t3_g0", 32'(got_ch[0]), 32'd0);
            check("t3_g1", 32'(got_ch[1]), 32'd1);
            check("t3_g2", 32'(got_ch[2]), 32'd3);
            check("t3_gap1", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
            check("t3_gap2", 32'(got_cyc[2] - got_cyc[1]), 32'd2);
        end
        data_in = 4'b0000; tick();
        data_in = 4'b1001;
        collect(8);
        check("t3_wrap_n", 32'(got_ch.size()), 32'd2);
        if (got_ch.size() > 0) check("t3_wrap_first", 32'(got_ch[0]), 32'd0);
        data_in = 4'b0000; tick(2);

        // Overrun while the consumer stalls, then clear
        bus.evt_ready = 1'b0;
        data_in = 4'b0010; tick();
        data_in = 4'b0000; tick();
        data_in = 4'b0010; tick();
        check("t4_overrun", 32'(overrun), 32'h2);
        check("t4_cnt",     32'(ovr_cnt), 32'd1);
        check("t4_valid",   32'(bus.evt_valid), 32'h1);
        check("t4_ch",      32'(bus.evt_ch), 32'h1);
        data_in = 4'b0000; tick();
        check("t4_ch_held", 32'(bus.evt_ch), 32'h1);
        ovr_clr = 1'b1; tick();
        ovr_clr = 1'b0;
        check("t4_clr_flag", 32'(overrun), 32'h0);
        check("t4_clr_cnt",  32'(ovr_cnt), 32'd0);
        bus.evt_ready = 1'b1; tick(4);

        // Masked channel; pending survives masking; counter saturation
        en_mask = 4'b1011;
        data_in = 4'b0100; tick();
        data_in = 4'b0000; tick(2);
        check("t5_masked", 32'(pending), 32'h0);
        en_mask = 4'b1111; bus.evt_ready = 1'b0;
        data_in = 4'b0100; tick();
        en_mask = 4'b1011; data_in = 4'b0000; tick(2);
        check("t5_masked_valid", 32'(bus.evt_valid), 32'h1);
        check("t5_masked_ch",    32'(bus.evt_ch), 32'h2);
        bus.evt_ready = 1'b1; tick();
        check("t5_masked_acc", 32'(pending), 32'h0);
        bus.evt_ready = 1'b0; en_mask = 4'b1111;
        for (int r = 0; r < 70; r++) begin
            data_in = 4'b1111; tick();
            data_in = 4'b0000; tick();
        end
        check("t5_sat", 32'(ovr_cnt), 32'd255);
        data_in = 4'b1111; tick();
        check("t5_sat_hold", 32'(ovr_cnt), 32'd255);
        data_in = 4'b0000; tick();
        ovr_clr = 1'b1; data_in = 4'b1111; tick();
        check("t5_clr_race_cnt", 32'(ovr_cnt), 32'd4);
        check("t5_clr_race_flg", 32'(overrun), 32'hf);
        ovr_clr = 1'b0; data_in = 4'b0000;

        // Rise during accept of the same channel; reset mid-offer
        ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
        bus.evt_ready = 1'b1;
        ok = 0;
        for (int c = 0; c < 30 && !ok; c++) begin
            tick();
            if (pending == 0 && !bus.evt_valid) ok = 1;
        end
        check("t6_drain", 32'(ok), 32'h1);
        bus.evt_ready = 1'b0;
        data_in = 4'b0010; tick();
        data_in = 4'b0000; tick(2);
        check("t6_offer_ch", 32'(bus.evt_ch), 32'h1);
        bus.evt_ready = 1'b1; data_in = 4'b0010; tick();
        check("t6_pend_kept", 32'(pending), 32'h2);
        check("t6_no_ovr",    32'(overrun), 32'h0);
        check("t6_bubble",    32'(bus.evt_valid), 32'h0);
        bus.evt_ready = 1'b0; data_in = 4'b0000; tick();
        check("t6_reoffer", 32'(bus.evt_valid), 32'h1);
        reset = 1'b1; tick();
        check("t6_rst_valid",   32'(bus.evt_valid), 32'h0);
        check("t6_rst_pending", 32'(pending), 32'h0);
        reset = 1'b0; tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire
